bus_arbiter8: RTL and testbench

- Round-robin arbiter that shares the 8-input, 32-bit result-select mux (one shared write-back/result bus) among 8 requesting units.
- Produces a one-hot grant and the matching 3-bit mux select, and holds the grant until the owner signals done.
- Enforces a hold-time limit (timeout) so that no owner can starve the others.
- Sits between the pipeline functional units and the shared 8:1 data mux; its oSel output drives the mux select input directly.

---
 rtl/bus_arbiter8.sv | 114 +++++++++++
 tb/tb_bus_arbiter8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for the shared 8:1 result bus.
// It issues a registered one-hot grant and the matching mux select.
// A grant is held until the owner releases it, and a hold-time limit
// forces a release so that no owner can starve the others.
//
// Handshake: iReq[k] is a level request. A grant is issued on the rising
// edge after the request is seen, so there is no combinational path from
// iReq to oGnt. The owner keeps the grant while iReq[o] stays high and
// iDone[o] stays low. The grant is released on the edge where iDone[o]=1,
// iReq[o]=0, or the hold counter reaches TIMEOUT-1. On that same edge the
// next winner is granted, with the releasing unit excluded. iDone bits of
// units that do not own the bus are ignored.
module bus_arbiter8 #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] iReq,
    input  logic [7:0] iDone,
    output logic [7:0] oGnt,
    output logic [2:0] oSel,
    output logic       oValid,
    output logic       oTimeout,
    output logic [0:0] oState
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] holdCnt;
    logic [2:0]    lastPtr;

    logic [3:0] idlePick;
    logic [3:0] relPick;
    logic       ownerDone;
    logic       ownerReq;
    logic       hitLimit;
    logic       relNow;

    // Returns {found, index}. The search starts one past ptr and wraps 7->0,
    // so ptr itself has the lowest priority.
    function automatic logic [3:0] pickNext(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!res[3] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Priority search and release decode for the current owner.
    always_comb begin
        idlePick  = pickNext(iReq, lastPtr);
        relPick   = pickNext(iReq & ~oGnt, oSel);
        ownerDone = iDone[oSel];
        ownerReq  = iReq[oSel];
        hitLimit  = (holdCnt == CW'(TIMEOUT - 1));
        relNow    = (state == GRANT) && (ownerDone || !ownerReq || hitLimit);
    end

    // Grant FSM, hold counter, round-robin pointer and timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            holdCnt  <= '0;
            lastPtr  <= 3'd7;
            oGnt     <= '0;
            oSel     <= '0;
            oValid   <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (idlePick[3]) begin
                        oGnt    <= 8'b1 << idlePick[2:0];
                        oSel    <= idlePick[2:0];
                        oValid  <= 1'b1;
                        holdCnt <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (relNow) begin
                        lastPtr <= oSel;
                        // A pulse is raised only when the limit alone caused the release.
                        oTimeout <= hitLimit && !ownerDone && ownerReq;
                        holdCnt  <= '0;
                        if (relPick[3]) begin
                            oGnt <= 8'b1 << relPick[2:0];
                            oSel <= relPick[2:0];
                        end else begin
                            oGnt   <= '0;
                            oValid <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        holdCnt <= holdCnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8. It covers rotation, timeout, abandon,
// done/timeout collision and asynchronous reset, and runs a continuous
// invariant monitor alongside the directed steps.
module tb_bus_arbiter8;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic [7:0] iReq;
    logic [7:0] iDone;
    logic [7:0] oGnt;
    logic [2:0] oSel;
    logic       oValid;
    logic       oTimeout;
    logic [0:0] oState;

    int checks = 0;
    int errors = 0;

    bus_arbiter8 #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .iReq     (iReq),
        .iDone    (iDone),
        .oGnt     (oGnt),
        .oSel     (oSel),
        .oValid   (oValid),
        .oTimeout (oTimeout),
        .oState   (oState)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic [7:0] g, input logic [2:0] s,
                             input logic v, input logic t);
        check({tag, "_gnt"}, 32'(oGnt), 32'(g));
        check({tag, "_sel"}, 32'(oSel), 32'(s));
        check({tag, "_valid"}, 32'(oValid), 32'(v));
        check({tag, "_timeout"}, 32'(oTimeout), 32'(t));
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Invariant monitor, sampled on the falling edge.
    logic [7:0] prevGnt = '0;
    int         runLen  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            check("inv_onehot0", 32'($onehot0(oGnt)), 32'd1);
            check("inv_valid_or", 32'(oValid), 32'(|oGnt));
            if (oValid) check("inv_gnt_sel", 32'(oGnt[oSel]), 32'd1);
            if (oGnt != 8'h00 && oGnt == prevGnt) runLen++;
            else runLen = (oGnt != 8'h00) ? 1 : 0;
            check("inv_hold_limit", 32'(runLen <= TIMEOUT), 32'd1);
            prevGnt = oGnt;
        end else begin
            prevGnt = '0;
            runLen  = 0;
        end
    end

    initial begin
        rst   = 1'b1;
        iReq  = 8'h00;
        iDone = 8'h00;
        #1;
        expectOut("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        check("reset_state", 32'(oState), 32'd0);
        step();
        step();
        rst = 1'b0;

        // 1: single request, then done.
        iReq = 8'h01;
        step();
        expectOut("t1_grant", 8'h01, 3'd0, 1'b1, 1'b0);
        check("t1_state", 32'(oState), 32'd1);
        iDone = 8'h01;
        step();
        expectOut("t1_release", 8'h00, 3'd0, 1'b0, 1'b0);
        iDone = 8'h00;
        iReq  = 8'h00;
        step();

        // 2: full rotation with back-to-back grants.
        doReset();
        iReq = 8'hFF;
        step();
        expectOut("t2_first", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            iDone = 8'b1 << k;
            step();
            check("t2_rot_gnt", 32'(oGnt), 32'(8'b1 << ((k + 1) % 8)));
            check("t2_rot_sel", 32'(oSel), 32'((k + 1) % 8));
        end
        iDone = 8'h00;
        iReq  = 8'h00;
        step();
        expectOut("t2_abandon_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // 3: timeout hands the bus to requester 2.
        doReset();
        iReq = 8'h05;
        step();
        expectOut("t3_grant", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            check("t3_hold", 32'(oGnt), 32'h01);
            check("t3_no_to", 32'(oTimeout), 32'd0);
        end
        step();
        expectOut("t3_timeout", 8'h04, 3'd2, 1'b1, 1'b1);
        step();
        expectOut("t3_pulse_end", 8'h04, 3'd2, 1'b1, 1'b0);
        iReq = 8'h00;
        step();
        expectOut("t3_idle", 8'h00, 3'd2, 1'b0, 1'b0);

        // 4: done coincides with the limit; normal release, no pulse.
        iReq = 8'h01;
        step();
        expectOut("t4_grant", 8'h01, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) step();
        check("t4_still_owner", 32'(oGnt), 32'h01);
        iDone = 8'h01;
        step();
        expectOut("t4_release", 8'h00, 3'd0, 1'b0, 1'b0);
        iDone = 8'h00;
        iReq  = 8'h00;
        step();
        check("t4_no_late_pulse", 32'(oTimeout), 32'd0);

        // 5: non-owner done ignored; owner 3 abandons; done with drop is one release.
        iReq = 8'h88;
        step();
        expectOut("t5_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
        iDone = 8'h80;
        step();
        expectOut("t5_foreign_done", 8'h08, 3'd3, 1'b1, 1'b0);
        iDone = 8'h00;
        iReq  = 8'h80;
        step();
        expectOut("t5_grant7", 8'h80, 3'd7, 1'b1, 1'b0);
        iReq  = 8'h00;
        iDone = 8'h80;
        step();
        expectOut("t5_drop_done", 8'h00, 3'd7, 1'b0, 1'b0);
        iDone = 8'h00;
        step();

        // 6: asynchronous reset mid-grant, then priority returns to 0.
        iReq = 8'h20;
        step();
        expectOut("t6_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expectOut("t6_async", 8'h00, 3'd0, 1'b0, 1'b0);
        iReq = 8'hFF;
        step();
        expectOut("t6_held", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expectOut("t6_after", 8'h01, 3'd0, 1'b1, 1'b0);
        iReq = 8'h00;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
